// File: rtl/tcspc_histogram_mem.sv
// Histogram memory for the TCSPC time-correlation analyser.
// Saturating per-bin counters behind a 2-stage read-modify-write pipe.
module tcspc_histogram_mem #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        command,
  input  logic              hit_valid,
  input  logic [ADDR_W-1:0] hit_bin,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int NBINS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_HOLD
  } state_e;

  state_e state_q, state_d;
  logic [1:0] cmd_q;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  logic s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_bin_q;
  logic s2_vld_q, s2_vld_d;
  logic [ADDR_W-1:0] s2_bin_q;
  logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;

  logic ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic rdr_q;
  logic [ADDR_W-1:0] rda_q;
  logic rdv_q;
  logic [CNT_W-1:0] rdd_q;

  logic [CNT_W-1:0] mem_q [NBINS];

  logic clr_trig;
  logic hold_cmd;
  logic s2_sat;
  logic [CNT_W-1:0] s2_inc;
  logic s2_we;
  logic fwd;
  logic accept;
  logic drop_hit;

  // Only an edge into 01 starts a sweep; holding 01 must not retrigger.
  assign clr_trig = (state_q != ST_CLEAR) &&
                    (command == 2'b01) &&
                    (cmd_q != 2'b01);
  assign hold_cmd = (command != 2'b00);

  assign s2_sat = (s2_cnt_q == CNT_MAX);
  assign s2_inc = s2_sat ? s2_cnt_q : s2_cnt_q + 1'b1;
  assign s2_we  = s2_vld_q && !clr_trig;
  assign fwd    = s1_vld_q && s2_vld_q &&
                  (s1_bin_q == s2_bin_q);

  assign accept   = hit_valid && (state_q == ST_RUN) && !clr_trig;
  assign drop_hit = hit_valid && !accept;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      ST_CLEAR: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST) begin
          state_d = hold_cmd ? ST_HOLD : ST_RUN;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (clr_trig) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end else begin
          state_d = hold_cmd ? ST_HOLD : ST_RUN;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  always_comb begin
    s1_vld_d = accept;
    s2_vld_d = s1_vld_q && !clr_trig;
    s2_cnt_d = fwd ? s2_inc : mem_q[s1_bin_q];
    ovf_d    = ovf_q;
    if (clr_trig) begin
      ovf_d = 1'b0;
    end else if (s2_vld_q && s2_sat) begin
      ovf_d = 1'b1;
    end
    // Zero first so a hit on the clear-entry cycle still counts.
    drop_d = clr_trig ? '0 : drop_q;
    if (drop_hit && (drop_d != DROP_MAX)) begin
      drop_d = drop_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cmd_q    <= 2'b00;
      sweep_q  <= '0;
      s1_vld_q <= 1'b0;
      s1_bin_q <= '0;
      s2_vld_q <= 1'b0;
      s2_bin_q <= '0;
      s2_cnt_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      rdr_q    <= 1'b0;
      rda_q    <= '0;
      rdv_q    <= 1'b0;
      rdd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= command;
      sweep_q  <= sweep_d;
      s1_vld_q <= s1_vld_d;
      s1_bin_q <= hit_bin;
      s2_vld_q <= s2_vld_d;
      s2_bin_q <= s1_bin_q;
      s2_cnt_q <= s2_cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      rdr_q    <= rd_req;
      rda_q    <= rd_addr;
      rdv_q    <= rdr_q;
      if (rdr_q) begin
        rdd_q <= mem_q[rda_q];
      end
    end
  end

  // Storage is left unreset so it can map onto RAM; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[sweep_q] <= '0;
    end else if (s2_we) begin
      mem_q[s2_bin_q] <= s2_inc;
    end
  end

  assign rd_valid   = rdv_q;
  assign rd_data    = rdd_q;
  assign busy       = (state_q == ST_CLEAR);
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: doc/tcspc_histogram_mem.md
# tcspc_histogram_mem

Parametrised histogram memory for the time-correlation analyser. It takes one time-bin index per cycle from the TDC/bin logic and increments a saturating counter for that bin through a 2-stage read-modify-write pipeline. It also provides a dedicated host readout port, a self-timed clear sweep, a hold mode, and sticky overflow/drop reporting. It replaces the fixed 128×32 data memory and sits between bin calculation and the readout/UART path.

## Interface
Parameters:
- ADDR_W, 7, bin index width; NBINS = 2^ADDR_W
- CNT_W, 32, bin counter width
- DROP_W, 16, dropped-hit counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- command  in  2  00 RUN, 01 CLEAR, 10 HOLD, 11 treated as HOLD
- hit_valid  in  1  a hit is present this cycle
- hit_bin  in  ADDR_W  bin index of the hit
- rd_req  in  1  readout request
- rd_addr  in  ADDR_W  bin to read
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  CNT_W  bin count
- busy  out  1  clear sweep in progress
- overflow  out  1  sticky flag: some bin saturated
- drop_count  out  DROP_W  saturating count of hits not accepted

## Operation
- States: CLEAR, RUN, HOLD.
  - Reset enters CLEAR, so memory is zeroed after power-up without host action.
- CLEAR: the sweep writes 0 to bins 0..NBINS-1, one bin per cycle, in ascending order.
  - busy=1 throughout the sweep.
  - At sweep end the block goes to RUN if command==00, otherwise HOLD.
- From RUN or HOLD, CLEAR is entered only on a command transition into 01 (previous sampled command ≠ 01). Holding 01 does not retrigger the sweep.
- On entering CLEAR:
  - both pipeline stage valids are flushed; in-flight increments are discarded;
  - overflow and drop_count are zeroed.
- RUN↔HOLD transitions follow command each cycle.
- Hit acceptance:
  - a hit is accepted only in RUN;
  - hit_valid in HOLD or CLEAR increments drop_count, which saturates at 2^DROP_W-1.
- Pipeline:
  - S1 registers bin/valid and reads memory.
  - S2 computes count+1 and writes it back.
- Same-bin hazard: if the S1 bin equals the S2 bin with both valid, S1 uses the S2 result (forwarding). N hits to one bin on N consecutive cycles yield exactly N.
- Saturation: a bin at 2^CNT_W-1 stays at that value, and overflow is set to 1 and held until the next clear.
- Readout: independent read port that is never stalled by hits.
  - It returns the committed memory value; an S2 write in the same cycle is not reflected.
  - rd_req during CLEAR returns the current swept content: 0 for bins already cleared, otherwise the old value.
- Hits are always processed before reads; there is no arbitration between them.

## Timing
- Reset values: state=CLEAR, sweep address=0, busy=1, rd_valid=0, rd_data=0, overflow=0, drop_count=0, pipeline valids=0.
- After rst_n deasserts, busy stays 1 for exactly NBINS cycles.
- Hit latency: a hit sampled at edge t is committed at edge t+2. An rd_req sampled at edge t+2 or later sees it.
- Read latency: 1 cycle. rd_req sampled at edge t gives rd_valid=1 and rd_data after edge t+1, for one cycle per request. Back-to-back reads are allowed.
- Clear latency:
  - command 01 sampled at edge t sets busy=1 after edge t;
  - the last bin is zeroed at edge t+NBINS;
  - busy=0 after that edge.
- A hit in the same cycle that CLEAR is entered is dropped and counted after the zeroing, so drop_count=1.
- Asserting rst_n mid-sweep or mid-pipeline immediately restores reset values and restarts the sweep from bin 0.

## Test plan
- Reset, then wait → busy=1 for 128 cycles, then 0; reading all 128 bins returns 0; rd_valid is one cycle after each rd_req.
- RUN, single hits to bins 3, 3, 127, 0 spaced 4 cycles apart → bin3=2, bin127=1, bin0=1, all others 0.
- RUN, 5 consecutive-cycle hits to bin 9, then alternating bins 9/10 for 6 cycles → bin9=8, bin10=3.
- CNT_W=4, 20 hits to bin 1 → bin1=15 and overflow=1; after a clear command, overflow=0 and bin1=0.
- HOLD, 7 hits → counts unchanged and drop_count=7. Then 01 held for 300 cycles → exactly one 128-cycle sweep, and drop_count reflects only hits after clear entry.
- Hits streaming in RUN with command switched to 01 mid-stream → in-flight increments are discarded, memory is all zero at busy falling, and hits resume counting after return to RUN.
